// File: rtl/ht_coeff_loader_pkg.sv
// Shared definitions for the Hilbert coefficient loader: FSM encoding and the
// default geometry shared with the coefficient source.
package ht_coeff_loader_pkg;

  localparam int HT_LENGTH_DEF     = 27;
  localparam int HT_DATA_WIDTH_DEF = 18;
  localparam int HT_ADDR_WIDTH_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } ht_state_e;

  // Bits needed to index a bank of len words (len >= 2).
  function automatic int idx_width(input int len);
    return (len > 2) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/ht_coeff_loader_if.sv
// Bundle of the source stream, MAC read port and status lines of the loader.
interface ht_coeff_loader_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10
);
  logic                         start;
  logic                         coeffEnable;
  logic signed [DATA_WIDTH-1:0] coeffIn;
  logic                         coeffSetFlag;
  logic        [ADDR_WIDTH-1:0] rdAddr;
  logic signed [DATA_WIDTH-1:0] rdData;
  logic                         coeffsLoaded;
  logic                         busy;
  logic                         loadError;
  logic                         symmetryError;

  modport slave (
    input  start, coeffIn, coeffSetFlag, rdAddr,
    output coeffEnable, rdData, coeffsLoaded, busy, loadError, symmetryError
  );

  modport master (
    output start, coeffIn, coeffSetFlag, rdAddr,
    input  coeffEnable, rdData, coeffsLoaded, busy, loadError, symmetryError
  );
endinterface

// File: rtl/ht_coeff_bank.sv
// Coefficient register file: one write port, one registered read port with
// out-of-range zeroing, and one combinational mirrored pair-read port.
module ht_coeff_bank
  import ht_coeff_loader_pkg::*;
#(
  parameter int LENGTH     = HT_LENGTH_DEF,
  parameter int DATA_WIDTH = HT_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = HT_ADDR_WIDTH_DEF,
  parameter int IDX_W      = idx_width(LENGTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic        [IDX_W-1:0]      wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic        [ADDR_WIDTH-1:0] rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  input  logic        [IDX_W-1:0]      pair_addr,
  output logic signed [DATA_WIDTH-1:0] pair_a,
  output logic signed [DATA_WIDTH-1:0] pair_b
);

  localparam logic [ADDR_WIDTH:0] LEN_EXT  = (ADDR_WIDTH+1)'(LENGTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(LENGTH - 1);

  logic signed [DATA_WIDTH-1:0] mem_q [LENGTH];
  logic signed [DATA_WIDTH-1:0] rd_data_d;
  logic signed [DATA_WIDTH-1:0] rd_data_q;
  logic        [IDX_W-1:0]      mirror_addr;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // The extra zero bit keeps the range test correct when LENGTH == 2^ADDR_WIDTH.
  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_addr} < LEN_EXT) begin
      rd_data_d = mem_q[rd_addr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign mirror_addr = LAST_IDX - pair_addr;
  assign pair_a      = mem_q[pair_addr];
  assign pair_b      = mem_q[mirror_addr];

endmodule

// File: rtl/ht_coeff_loader.sv
// Loads LENGTH coefficients from the serial source, validates length and
// antisymmetry, then serves them to the MAC engine through the bank read port.
module ht_coeff_loader
  import ht_coeff_loader_pkg::*;
#(
  parameter int LENGTH     = HT_LENGTH_DEF,
  parameter int DATA_WIDTH = HT_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = HT_ADDR_WIDTH_DEF
) (
  input logic               clock,
  input logic               reset,
  ht_coeff_loader_if.slave  bus
);

  localparam int                  IDX_W    = idx_width(LENGTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] MID_IDX  = ADDR_WIDTH'((LENGTH - 1) / 2);

  ht_state_e                    state_q, state_d;
  logic        [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                         load_error_q, load_error_d;
  logic                         sym_error_q, sym_error_d;
  logic                         bank_wr_en;
  logic signed [DATA_WIDTH-1:0] pair_a, pair_b;
  logic signed [DATA_WIDTH:0]   pair_sum;

  ht_coeff_bank #(
    .LENGTH     (LENGTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (bank_wr_en),
    .wr_addr   (idx_q[IDX_W-1:0]),
    .wr_data   (bus.coeffIn),
    .rd_addr   (bus.rdAddr),
    .rd_data   (bus.rdData),
    .pair_addr (idx_q[IDX_W-1:0]),
    .pair_a    (pair_a),
    .pair_b    (pair_b)
  );

  // One extra bit so that -2^(W-1) + -2^(W-1) cannot wrap to zero.
  assign pair_sum = {pair_a[DATA_WIDTH-1], pair_a} + {pair_b[DATA_WIDTH-1], pair_b};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    load_error_d = load_error_q;
    sym_error_d  = sym_error_q;
    bank_wr_en   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d      = ST_PRIME;
          idx_d        = '0;
          load_error_d = 1'b0;
          sym_error_d  = 1'b0;
        end
      end
      ST_PRIME: begin
        state_d = ST_LOAD;
        idx_d   = '0;
      end
      ST_LOAD: begin
        bank_wr_en = 1'b1;
        idx_d      = idx_q + ADDR_WIDTH'(1);
        if (bus.coeffSetFlag && (idx_q == LAST_IDX)) begin
          state_d = ST_CHECK;
          idx_d   = '0;
        end else if (bus.coeffSetFlag || (idx_q == LAST_IDX)) begin
          state_d      = ST_DONE;
          idx_d        = '0;
          load_error_d = 1'b1;
        end
      end
      ST_CHECK: begin
        if (pair_sum != '0) begin
          sym_error_d = 1'b1;
        end
        if (idx_q == MID_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      load_error_q <= 1'b0;
      sym_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      load_error_q <= load_error_d;
      sym_error_q  <= sym_error_d;
    end
  end

  assign bus.coeffEnable   = (state_q == ST_PRIME) || (state_q == ST_LOAD);
  assign bus.busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.coeffsLoaded  = (state_q == ST_DONE) && !load_error_q;
  assign bus.loadError     = load_error_q;
  assign bus.symmetryError = sym_error_q;

endmodule

// File: tb/tb_ht_coeff_loader.sv
// Self-checking bench: behavioural coefficient source, scenario table for the
// load/check outcomes, and a scoreboard on the registered read port.
module tb_ht_coeff_loader;

  localparam int LEN = 27;
  localparam int DW  = 18;
  localparam int AW  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ht_coeff_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ht_coeff_loader #(
    .LENGTH     (LEN),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int coef [LEN];
  int flag_at;
  int src_cnt;
  int exp_q  [$];
  int addr_q [$];

  typedef struct {
    int flag_at;
    int bad_idx;
    int bad_val;
    int poke;
    int exp_loaded;
    int exp_lderr;
    int exp_symerr;
    int exp_en;
    int exp_busy;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  function automatic void load_nominal();
    coef = '{-25, 0, -51, 0, -92, 0, -155, 0, -256, 0, -450, 0, -2018, 0,
             2018, 0, 450, 0, 256, 0, 155, 0, 92, 0, 51, 0, 25};
  endfunction

  // Source: first word one cycle after enable is sampled high; counter
  // clears only while enable is low; flag and word held once flagged.
  always @(posedge clk) begin
    if (!bus.coeffEnable) begin
      src_cnt          <= 0;
      bus.coeffIn      <= '0;
      bus.coeffSetFlag <= 1'b0;
    end else begin
      bus.coeffIn      <= DW'(coef[src_cnt]);
      bus.coeffSetFlag <= (src_cnt == flag_at);
      if (src_cnt != flag_at && src_cnt < LEN - 1) begin
        src_cnt <= src_cnt + 1;
      end
    end
  end

  task automatic run_load(input int poke, output int en_cyc, output int busy_cyc,
                          output int started);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    started  = (bus.busy && !bus.coeffsLoaded) ? 1 : 0;
    en_cyc   = 0;
    busy_cyc = 0;
    while (bus.busy && busy_cyc < 200) begin
      if (bus.coeffEnable) en_cyc++;
      busy_cyc++;
      bus.start = (poke != 0 && (busy_cyc == 5 || busy_cyc == 35)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic read_all(input string tag);
    int addrs [$];
    for (int a = 0; a < LEN; a++) addrs.push_back(a);
    addrs.push_back(30);
    addrs.push_back(1023);
    foreach (addrs[k]) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        chk($sformatf("%s rdData[%0d]", tag, addr_q.pop_front()), int'(bus.rdData),
            exp_q.pop_front());
      end
      bus.rdAddr = AW'(addrs[k]);
      addr_q.push_back(addrs[k]);
      exp_q.push_back(addrs[k] < LEN ? coef[addrs[k]] : 0);
    end
    @(negedge clk);
    chk($sformatf("%s rdData[%0d]", tag, addr_q.pop_front()), int'(bus.rdData),
        exp_q.pop_front());
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " coeffEnable"},   int'(bus.coeffEnable),   0);
    chk({tag, " busy"},          int'(bus.busy),          0);
    chk({tag, " coeffsLoaded"},  int'(bus.coeffsLoaded),  0);
    chk({tag, " loadError"},     int'(bus.loadError),     0);
    chk({tag, " symmetryError"}, int'(bus.symmetryError), 0);
    chk({tag, " rdData"},        int'(bus.rdData),        0);
  endtask

  initial begin
    int en_cyc, busy_cyc, started;

    bus.start  = 1'b0;
    bus.rdAddr = AW'(12);
    flag_at    = LEN - 1;
    load_nominal();

    //            flag  bad  val poke ld le se  en busy
    vecs[0] = '{  26,  -1,  0,  0,  1, 0, 0, 28, 42};
    vecs[1] = '{  26,   3,  5,  0,  1, 0, 1, 28, 42};
    vecs[2] = '{  26,  13,  1,  0,  1, 0, 1, 28, 42};
    vecs[3] = '{  19,  -1,  0,  0,  0, 1, 0, 21, 21};
    vecs[4] = '{  -1,  -1,  0,  0,  0, 1, 0, 28, 28};
    vecs[5] = '{  26,  -1,  0,  1,  1, 0, 0, 28, 42};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      load_nominal();
      if (vecs[i].bad_idx >= 0) coef[vecs[i].bad_idx] = vecs[i].bad_val;
      flag_at = vecs[i].flag_at;
      run_load(vecs[i].poke, en_cyc, busy_cyc, started);
      chk($sformatf("v%0d started", i),       started,                    1);
      chk($sformatf("v%0d enable_cycles", i), en_cyc,                     vecs[i].exp_en);
      chk($sformatf("v%0d busy_cycles", i),   busy_cyc,                   vecs[i].exp_busy);
      chk($sformatf("v%0d enable_after", i),  int'(bus.coeffEnable),      0);
      chk($sformatf("v%0d coeffsLoaded", i),  int'(bus.coeffsLoaded),     vecs[i].exp_loaded);
      chk($sformatf("v%0d loadError", i),     int'(bus.loadError),        vecs[i].exp_lderr);
      chk($sformatf("v%0d symmetryError", i), int'(bus.symmetryError),    vecs[i].exp_symerr);
    end

    read_all("nominal");

    // Abort a reload partway through LOAD with reset.
    bus.rdAddr = AW'(12);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midload busy",   int'(bus.busy),        1);
    chk("midload enable", int'(bus.coeffEnable), 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midload_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_load(0, en_cyc, busy_cyc, started);
    chk("reload started",       started,                 1);
    chk("reload enable_cycles", en_cyc,                  28);
    chk("reload busy_cycles",   busy_cyc,                42);
    chk("reload coeffsLoaded",  int'(bus.coeffsLoaded),  1);
    chk("reload loadError",     int'(bus.loadError),     0);
    chk("reload symmetryError", int'(bus.symmetryError), 0);
    read_all("reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
